stream_mux: RTL and testbench

- Registered N-channel, W-bit multiplexer with valid/ready handshake on every input and on the output.
- Generalises the combinational 16-bit two-way mux to:
  - parametrised width and channel count;
  - two selection modes: external select, or round-robin arbitration;
  - a one-deep output register.
- Sits between multiple word producers (e.g. CPU data path, I/O, ROM loader) and a single downstream consumer.

---
 rtl/stream_mux_pkg.sv | 21 ++
 rtl/stream_mux_rr_arbiter.sv | 34 +++
 rtl/stream_mux.sv | 122 ++++++++++++
 tb/tb_stream_mux.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux block and its arbiter.
package stream_mux_pkg;

  // Channel selection modes.
  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Ceiling log2. Sizes channel indices and checks SELW.
  function automatic int sm_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter. It searches from last+1 upward with
// wrap-around and grants the first requester. The output is a one-hot
// grant plus the binary index of the granted channel.
module stream_mux_rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int IDXW     = 2
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [IDXW-1:0]     last_i,
  output logic [CHANNELS-1:0] grant_o,
  output logic [IDXW-1:0]     idx_o
);

  // Priority search starting just after the last granted channel.
  always_comb begin
    logic found;
    int   pos;
    found   = 1'b0;
    pos     = 0;
    grant_o = '0;
    idx_o   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      pos = (int'(last_i) + k) % CHANNELS;
      for (int j = 0; j < CHANNELS; j++) begin
        if (!found && (j == pos) && req_i[j]) begin
          found      = 1'b1;
          grant_o[j] = 1'b1;
          idx_o      = IDXW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// Registered N-channel stream multiplexer with a valid/ready handshake.
// The channel is chosen either by an external select or by a round-robin
// arbiter. The result goes into a one-deep output register, which can
// drain and reload in the same cycle.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2,
  parameter int MODE     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Keep internal indices at least one bit wide.
  localparam int IDXW = (sm_clog2(CHANNELS) < 1) ? 1 : sm_clog2(CHANNELS);

  logic                can_load;
  logic                xfer;
  logic [CHANNELS-1:0] grant;
  logic [IDXW-1:0]     gidx;
  logic [WIDTH-1:0]    gdata;

  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0]     out_chan_q,  out_chan_d;
  logic                out_valid_q, out_valid_d;

  // A new word can enter when the register is empty or is being drained now.
  assign can_load = !out_valid_q || out_ready;
  assign in_ready = grant & {CHANNELS{can_load & ~reset}};
  assign xfer     = |(in_valid & in_ready);

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [IDXW-1:0] last_q, last_d;
      logic            unused_sel;

      assign unused_sel = ^sel;

      stream_mux_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .IDXW     (IDXW)
      ) u_arb (
        .req_i   (in_valid),
        .last_i  (last_q),
        .grant_o (grant),
        .idx_o   (gidx)
      );

      // The pointer advances only when a word actually moves.
      assign last_d = xfer ? gidx : last_q;

      // Reset parks the pointer on the top channel, so channel 0 wins first.
      always_ff @(posedge clk) begin
        if (reset) last_q <= IDXW'(CHANNELS - 1);
        else       last_q <= last_d;
      end
    end else begin : g_sel
      // Decode the external select. Out-of-range values grant nothing.
      always_comb begin
        grant = '0;
        gidx  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
          if (int'(sel) == i) begin
            grant[i] = in_valid[i];
            gidx     = IDXW'(i);
          end
        end
      end
    end
  endgenerate

  // Pick the granted channel's word out of the packed input bus.
  always_comb begin
    gdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Next state of the output register: load, drain, or hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gdata;
      out_chan_d  = SELW'(gidx);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register. Reset drops any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux.sv
// Testbench for stream_mux. Two instances (external select and round-robin)
// share one stimulus. Each is compared cycle by cycle against a
// transaction-level model built from the handshake rules.
module tb_stream_mux;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [SW-1:0]   sel;
  logic            out_ready;

  logic [CH-1:0]   rdy0, rdy1;
  logic [W-1:0]    od0, od1;
  logic [SW-1:0]   oc0, oc1;
  logic            ov0, ov1;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 is the external-select instance, index 1 is round-robin.
  int            mov [2];
  int            mod [2];
  int            moc [2];
  int            mptr = CH - 1;
  int            g   [2];
  logic [CH-1:0] erdy [2];

  always #5 clk = ~clk;

  stream_mux #(.WIDTH(W), .CHANNELS(CH), .SELW(SW), .MODE(0)) u_sel (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .sel(sel), .out_data(od0), .out_chan(oc0),
    .out_valid(ov0), .out_ready(out_ready)
  );

  stream_mux #(.WIDTH(W), .CHANNELS(CH), .SELW(SW), .MODE(1)) u_rr (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .sel(sel), .out_data(od1), .out_chan(oc1),
    .out_valid(ov1), .out_ready(out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] word(input int i);
    return in_data[i*W +: W];
  endfunction

  task automatic set_words(input logic [W-1:0] base);
    for (int i = 0; i < CH; i++) in_data[i*W +: W] = base + W'(i);
  endtask

  // Work out which channel each instance should grant this cycle.
  task automatic predict();
    int c;
    for (int m = 0; m < 2; m++) begin
      g[m] = -1;
      if (m == 0) begin
        if (int'(sel) < CH && in_valid[sel[1:0]]) g[0] = int'(sel);
      end else begin
        for (int k = 1; k <= CH; k++) begin
          c = (mptr + k) % CH;
          if (g[1] < 0 && in_valid[c]) g[1] = c;
        end
      end
      erdy[m] = '0;
      if (g[m] >= 0 && (mov[m] == 0 || out_ready) && !reset) erdy[m][g[m]] = 1'b1;
    end
  endtask

  // Apply the effect of the clock edge to the model.
  task automatic update();
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        mov[m] = 0; mod[m] = 0; moc[m] = 0;
        if (m == 1) mptr = CH - 1;
      end else if (erdy[m] != '0) begin
        mod[m] = int'(word(g[m]));
        moc[m] = g[m];
        mov[m] = 1;
        if (m == 1) mptr = g[1];
      end else if (out_ready) begin
        mov[m] = 0;
      end
    end
  endtask

  // One clock: check in_ready against the inputs already applied, then check the registered outputs.
  task automatic step(input string tag);
    #1;
    predict();
    check_eq({tag, ":rdy0"}, 32'(rdy0), 32'(erdy[0]));
    check_eq({tag, ":rdy1"}, 32'(rdy1), 32'(erdy[1]));
    @(posedge clk);
    update();
    #1;
    check_eq({tag, ":ov0"}, 32'(ov0), 32'(mov[0]));
    check_eq({tag, ":od0"}, 32'(od0), 32'(mod[0]));
    check_eq({tag, ":oc0"}, 32'(oc0), 32'(moc[0]));
    check_eq({tag, ":ov1"}, 32'(ov1), 32'(mov[1]));
    check_eq({tag, ":od1"}, 32'(od1), 32'(mod[1]));
    check_eq({tag, ":oc1"}, 32'(oc1), 32'(moc[1]));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '1;
    sel       = '0;
    out_ready = 1'b1;
    set_words(16'h1000);

    // Reset held for two cycles while every channel is valid.
    step("rst");
    #1;
    check_eq("rst_rdy", 32'(rdy1), 32'h0);
    step("rst");
    check_eq("rst_ov", 32'(ov1), 32'h0);
    check_eq("rst_od", 32'(od1), 32'h0);

    // Round-robin fairness: channel 0 goes first, then a steady rotation.
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step("rr_fair");
      check_eq("rr_fair_chan", 32'(oc1), 32'(k % CH));
      check_eq("rr_fair_data", 32'(od1), 32'h1000 + 32'(k % CH));
      check_eq("rr_fair_valid", 32'(ov1), 32'h1);
    end

    // External select picks channel 2.
    sel      = 3'd2;
    in_valid = 4'b0100;
    in_data[2*W +: W] = 16'hBEEF;
    #1;
    check_eq("sel2_rdy", 32'(rdy0), 32'b0100);
    step("sel2");
    check_eq("sel2_data", 32'(od0), 32'hBEEF);
    check_eq("sel2_chan", 32'(oc0), 32'h2);
    check_eq("sel2_valid", 32'(ov0), 32'h1);

    // An out-of-range select grants nothing.
    sel      = 3'd5;
    in_valid = 4'b1111;
    #1;
    check_eq("sel5_rdy", 32'(rdy0), 32'h0);
    step("sel5");

    // Backpressure: the held word stays put and nothing is accepted.
    sel = '0;
    set_words(16'h1000);
    reset = 1'b1;
    step("bp_rst");
    reset = 1'b0;
    step("bp_ld0");
    step("bp_ld1");
    check_eq("bp_hold_data0", 32'(od1), 32'h1001);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("bp_stall_rdy", 32'(rdy1), 32'h0);
      step("bp_stall");
      check_eq("bp_stall_data", 32'(od1), 32'h1001);
      check_eq("bp_stall_valid", 32'(ov1), 32'h1);
    end
    out_ready = 1'b1;
    step("bp_release");
    check_eq("bp_reload_valid", 32'(ov1), 32'h1);
    check_eq("bp_reload_data", 32'(od1), 32'h1002);

    // Sparse round-robin: after granting channel 1, requests on 0 and 3 go 3 then 0.
    reset = 1'b1;
    step("sp_rst");
    reset    = 1'b0;
    in_valid = 4'b0011;
    step("sp_a");
    step("sp_b");
    check_eq("sp_last1", 32'(oc1), 32'h1);
    in_valid = 4'b1001;
    step("sp_c");
    check_eq("sp_ch3", 32'(oc1), 32'h3);
    step("sp_d");
    check_eq("sp_ch0", 32'(oc1), 32'h0);
    in_valid = 4'b0000;
    step("sp_drain");
    check_eq("sp_drain_valid", 32'(ov1), 32'h0);

    // Reset during a stall drops the held word and restarts the pointer.
    in_valid = 4'b1111;
    step("rs_ld");
    check_eq("rs_ld_chan", 32'(oc1), 32'h1);
    out_ready = 1'b0;
    step("rs_stall");
    reset = 1'b1;
    step("rs_pulse");
    check_eq("rs_valid", 32'(ov1), 32'h0);
    reset     = 1'b0;
    out_ready = 1'b1;
    step("rs_after");
    check_eq("rs_first_chan", 32'(oc1), 32'h0);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < CH; i++) in_data[i*W +: W] = W'($urandom);
      in_valid  = CH'($urandom_range(0, 15));
      sel       = SW'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 31) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
